// File: rtl/stopwatch_ctrl_if.sv
// Button levels into the stopwatch sequencer and its controls out to the
// time counter / display mux.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       tick;
  logic       clr_cnt;
  logic       running;
  logic       freeze;
  logic [1:0] state;

  modport master (
    output btn_ss, btn_lap, btn_clr,
    input  tick, clr_cnt, running, freeze, state
  );

  modport slave (
    input  btn_ss, btn_lap, btn_clr,
    output tick, clr_cnt, running, freeze, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: press detection, run/pause/lap FSM, tick prescaler.
// Define STOPWATCH_LAP_EN to build the LAP state, lap button logic and freeze.
module stopwatch_ctrl #(
  parameter int CLK_DIV = 270000
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_cnt;
  logic          prev_ss;
  logic          prev_clr;
  logic          tick_q;
  logic          clr_q;
  logic          ev_ss;
  logic          ev_clr;
  logic          wrap;

  // A press is the falling edge of the conditioned level.
  assign ev_ss  = prev_ss & ~bus.btn_ss;
  assign ev_clr = prev_clr & ~bus.btn_clr;
  assign wrap   = (div_cnt == DIV_LAST);

`ifdef STOPWATCH_LAP_EN
  logic prev_lap;
  logic ev_lap;
  assign ev_lap = prev_lap & ~bus.btn_lap;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = bus.btn_lap;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_cnt  <= '0;
      prev_ss  <= 1'b0;
      prev_clr <= 1'b0;
      tick_q   <= 1'b0;
      clr_q    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      prev_lap <= 1'b0;
`endif
    end else begin
      prev_ss  <= bus.btn_ss;
      prev_clr <= bus.btn_clr;
`ifdef STOPWATCH_LAP_EN
      prev_lap <= bus.btn_lap;
`endif
      tick_q <= 1'b0;
      clr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          div_cnt <= '0;
          if (ev_clr)     clr_q   <= 1'b1;
          else if (ev_ss) state_q <= RUN;
        end
        RUN: begin
          // Leaving for PAUSE holds the prescaler, suppressing a coincident wrap.
          if (ev_ss) begin
            state_q <= PAUSE;
          end else begin
            if (wrap) begin
              div_cnt <= '0;
              tick_q  <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
`ifdef STOPWATCH_LAP_EN
            if (ev_lap) state_q <= LAP;
`endif
          end
        end
`ifdef STOPWATCH_LAP_EN
        LAP: begin
          if (ev_ss) begin
            state_q <= PAUSE;
          end else begin
            if (wrap) begin
              div_cnt <= '0;
              tick_q  <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
            if (ev_lap) state_q <= RUN;
          end
        end
`endif
        PAUSE: begin
          if (ev_clr) begin
            state_q <= IDLE;
            clr_q   <= 1'b1;
            div_cnt <= '0;
          end else if (ev_ss) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tick    = tick_q;
  assign bus.clr_cnt = clr_q;
  assign bus.state   = state_q;
  assign bus.running = (state_q == RUN) || (state_q == LAP);
`ifdef STOPWATCH_LAP_EN
  assign bus.freeze  = (state_q == LAP);
`else
  assign bus.freeze  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_DIV=4: vector table plus
// hand-written multi-cycle sequences.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam logic [1:0] LAP_ST = LAP_EN ? 2'b10 : 2'b01;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;

  stopwatch_ctrl_if u_if ();

  stopwatch_ctrl #(.CLK_DIV(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ss;
    logic       lap;
    logic       clr;
    logic       tick;
    logic       clr_cnt;
    logic       run;
    logic       frz;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic l, logic c,
                              logic t, logic cc, logic rn, logic f, logic [1:0] st);
    vec_t v;
    v.rst = r; v.ss = s; v.lap = l; v.clr = c;
    v.tick = t; v.clr_cnt = cc; v.run = rn; v.frz = f; v.st = st;
    return v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, logic l, logic c);
    u_if.btn_ss  = s;
    u_if.btn_lap = l;
    u_if.btn_clr = c;
  endtask

  // scoreboard
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(string tag, logic t, logic cc, logic rn, logic f, logic [1:0] st);
    chk({tag, ".tick"},    8'(u_if.tick),    8'(t));
    chk({tag, ".clr_cnt"}, 8'(u_if.clr_cnt), 8'(cc));
    chk({tag, ".running"}, 8'(u_if.running), 8'(rn));
    chk({tag, ".freeze"},  8'(u_if.freeze),  8'(f));
    chk({tag, ".state"},   8'(u_if.state),   8'(st));
  endtask

  initial begin
    int ticks;
    int doubles;
    int first;
    logic prev_t;

    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1;
    drive(0, 0, 0);

    //               rst ss lap clr | tick clr run frz st
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 2'b00)); // reset
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01)); // RUN entry, div 0
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 2'b01)); // first tick, entry+4
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0, 2'b01)); // div 1
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 2'b11)); // PAUSE, div held 1
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 2'b11));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01)); // resume, div 1
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 2'b01)); // tick 3 after resume
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01)); // clr ignored in RUN
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0, 2'b01)); // div 3
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 2'b11)); // wrap suppressed
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01)); // resume at div 3
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 2'b11));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 2'b00)); // clear from PAUSE
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 2'b00)); // clear in IDLE
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01)); // RUN, div 0
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 2'b01)); // div back to 0

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].ss, vecs[i].lap, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].tick, vecs[i].clr_cnt,
              vecs[i].run, vecs[i].frz, vecs[i].st);
    end

    // lap toggling keeps tick spacing (RUN, div 0 here)
    drive(0, 1, 0); step();                               // div 1
    drive(0, 0, 0); step();                               // div 2
    chk_all("lap_enter", 0, 0, 1, LAP_EN, LAP_ST);
    step();                                               // div 3
    step();
    chk_all("lap_tick", 1, 0, 1, LAP_EN, LAP_ST);
    drive(0, 1, 0); step();                               // div 1
    drive(0, 0, 0); step();                               // div 2
    chk_all("lap_exit", 0, 0, 1, 0, 2'b01);
    drive(0, 1, 0); step();                               // div 3
    drive(0, 0, 0); step();
    chk_all("lap_again", 1, 0, 1, LAP_EN, LAP_ST);
    drive(1, 0, 0); step();
    drive(0, 0, 0); step();
    chk_all("lap_to_pause", 0, 0, 0, 0, 2'b11);

    // simultaneous clr+ss in PAUSE: clear wins
    drive(1, 0, 1); step();
    drive(0, 0, 0); step();
    chk_all("pause_clr_ss", 0, 1, 0, 0, 2'b00);
    step();
    chk_all("pause_clr_ss_after", 0, 0, 0, 0, 2'b00);

    // simultaneous ss+lap in RUN: start/stop wins
    drive(1, 0, 0); step();
    drive(0, 0, 0); step();
    chk_all("restart", 0, 0, 1, 0, 2'b01);
    drive(1, 1, 0); step();                               // div 1
    drive(0, 0, 0); step();
    chk_all("run_ss_lap", 0, 0, 0, 0, 2'b11);

    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (u_if.tick) ticks++;
    end
    chk("pause_ticks", 8'(ticks), 8'd0);

    // resume from held div 1, ss held low afterwards
    drive(1, 0, 0); step();
    drive(0, 0, 0); step();
    chk("resume_state", 8'(u_if.state), 8'd1);
    ticks = 0; doubles = 0; prev_t = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (u_if.tick) ticks++;
      if (u_if.tick && prev_t) doubles++;
      prev_t = u_if.tick;
    end
    chk("run16_ticks", 8'(ticks), 8'd4);
    chk("run16_doubles", 8'(doubles), 8'd0);
    chk("held_low_state", 8'(u_if.state), 8'd1);

    // reset in LAP mid-prescale
    drive(0, 1, 0); step();
    drive(0, 0, 0); step();
    chk_all("pre_rst_lap", u_if.tick, 0, 1, LAP_EN, LAP_ST);
    step();
    rst = 1'b1; step();
    chk_all("mid_rst", 0, 0, 0, 0, 2'b00);
    rst = 1'b0;
    drive(1, 0, 0); step();
    drive(0, 0, 0); step();
    chk_all("post_rst_run", 0, 0, 1, 0, 2'b01);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (u_if.tick && first == 0) first = k;
    end
    chk("post_rst_first_tick", 8'(first), 8'd4);

    // button held through reset gives one event at release
    rst = 1'b1; drive(1, 0, 0); step();
    chk_all("held_rst", 0, 0, 0, 0, 2'b00);
    rst = 1'b0; step();
    chk_all("held_after_rst", 0, 0, 0, 0, 2'b00);
    drive(0, 0, 0); step();
    chk_all("held_release", 0, 0, 1, 0, 2'b01);
    step();
    chk_all("held_release_stay", 0, 0, 1, 0, 2'b01);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath. It detects press events on the debounced start/stop, lap and clear button levels as 1→0 transitions. It runs a four-state run/pause/lap FSM and drives the time counter through a prescaled `tick` enable, a one-cycle clear pulse, and a display-freeze flag. It sits between the button conditioning and the BCD time counter / display mux.

## Interface
- `CLK_DIV`, 270000, clock cycles per `tick` (27 MHz → 100 Hz); legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_ss`  in  1  start/stop button level; press event = previous sample 1, current sample 0.
- `btn_lap`  in  1  lap button level; same event rule.
- `btn_clr`  in  1  clear button level; same event rule.
- `tick`  out  1  one-cycle count enable to the time counter.
- `clr_cnt`  out  1  one-cycle synchronous clear pulse to the time counter.
- `running`  out  1  1 in RUN or LAP.
- `freeze`  out  1  display hold; 1 only in LAP.
- `state`  out  2  IDLE=00, RUN=01, LAP=10, PAUSE=11.

## Operation
- Each button has a previous-sample register. Press event `ev_x` = `prev_x & ~btn_x`, evaluated combinationally. `prev_x <= btn_x` every cycle.
- Event priority in a single cycle: clr > ss > lap. Only the highest-priority event that is legal in the current state acts. Lower-priority events in that cycle are dropped.
- IDLE:
  - ev_ss → RUN.
  - ev_clr → clr_cnt pulse, stay in IDLE.
  - ev_lap is ignored.
- RUN:
  - ev_ss → PAUSE.
  - ev_lap → LAP.
  - ev_clr is ignored.
- LAP: counting continues and `freeze`=1.
  - ev_lap → RUN.
  - ev_ss → PAUSE, which releases `freeze`.
  - ev_clr is ignored.
- PAUSE:
  - ev_ss → RUN; the prescaler resumes from its held value.
  - ev_clr → IDLE with a clr_cnt pulse; the prescaler is zeroed.
  - ev_lap is ignored.
- Prescaler `div_cnt`, width $clog2(CLK_DIV):
  - Advances only in RUN or LAP.
  - At count CLK_DIV-1 it wraps to 0 and sets `tick`.
  - Holds its value in PAUSE.
  - Forced to 0 in IDLE.
- All outputs are registered, and `running`, `freeze` and `state` decode the registered state.
- Reset: state=IDLE, div_cnt=0, all prev_x=0, and tick, clr_cnt, running, freeze, state all 0.
- Reset mid-operation discards the count phase; no clr_cnt is issued.
- A button held at 1 through reset produces one event at its first release after reset.

## Timing
- Event latency: the event is seen in cycle N. `state`, `running`, `freeze` and `clr_cnt` reflect it after the rising edge ending cycle N, i.e. 1 cycle after the button falls.
- `clr_cnt` is high for exactly 1 cycle per accepted clear event.
- First `tick` after entering RUN from IDLE: div_cnt=0 at the entry edge E. The tick is registered at edge E+CLK_DIV and is high for one cycle.
- Steady state: one tick every CLK_DIV cycles and never two consecutive high cycles, because CLK_DIV ≥ 2.
- RUN↔LAP transitions do not disturb div_cnt or tick spacing.
- Leaving RUN/LAP for PAUSE at edge P: no tick is registered at edge P or later until RUN is re-entered. If a wrap coincides with P, that tick is suppressed and div_cnt holds CLK_DIV-1.
- A tick already registered at edge P-1 still appears in the cycle after P-1.
- A press is a single event regardless of how long the button stays low; a new event needs a 0→1→0 sequence.

## Configuration
- `STOPWATCH_LAP_EN` defined: the LAP state, `btn_lap` event logic and `freeze` behave as above.
- `STOPWATCH_LAP_EN` undefined:
  - The LAP state and the lap edge register are not built.
  - `btn_lap` is ignored.
  - `freeze` is tied to 0.
  - `state` never takes the value 10.
  - All other behaviour is unchanged.

## Test plan
All scenarios use CLK_DIV=4.
- Reset with all buttons at 0 → all outputs 0 and state=00. Pulse `btn_ss` 1 for 3 cycles then 0 → state=01 one cycle after the fall; first tick 4 cycles after the entry edge, then every 4 cycles.
- RUN for 10 cycles, then ss event → state=11, tick stays 0 for 20 cycles. Second ss event → state=01, next tick spacing continues from the held div_cnt, so total ticks over 16 RUN cycles = 4.
- PAUSE, then clr event → state=00 and exactly one clr_cnt pulse. Another clr event in IDLE → a second single pulse. clr event during RUN → no pulse, state stays 01.
- RUN, then lap event → state=10, freeze=1, tick spacing unchanged. Lap again → state=01, freeze=0. Lap then ss → state=11, freeze=0.
- Simultaneous falls on btn_clr and btn_ss in PAUSE → IDLE with a clr_cnt pulse. Simultaneous ss and lap falls in RUN → PAUSE.
- Assert `rst` for 1 cycle in LAP mid-prescale → next cycle all outputs 0, state=00. After an ss event the first tick comes 4 cycles after entry. With `STOPWATCH_LAP_EN` undefined, the lap event in RUN leaves state=01 and freeze=0.
